reflet_align_bridge: RTL and testbench



---
 rtl/reflet_align_bridge.sv | 151 +++++++++++++++
 tb/tb_reflet_align_bridge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reflet_align_bridge.sv
// rtl/reflet_align_bridge.sv - byte-addressed CPU load/store to word memory bridge
// Splits word-straddling accesses, does read-modify-write for partial stores, zero-extends loads.
module reflet_align_bridge #(
  parameter int wordsize  = 32,
  parameter int addr_size = 32,
  localparam int WB  = wordsize / 8,
  localparam int LWB = $clog2(WB),
  localparam int NW  = LWB + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [1:0]               cpu_size,
  input  logic [addr_size-1:0]     cpu_addr,
  input  logic [wordsize-1:0]      cpu_wdata,
  output logic [wordsize-1:0]      cpu_rdata,
  output logic                     cpu_ready,
  output logic [addr_size-LWB-1:0] mem_addr,
  output logic [wordsize-1:0]      mem_wdata,
  output logic                     mem_we,
  input  logic [wordsize-1:0]      mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_RD_END, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  state_t                   r_state, w_next;
  logic                     r_we;
  logic                     r_span;
  logic [LWB-1:0]           r_off;
  logic [NW-1:0]            r_n;
  logic [addr_size-LWB-1:0] r_lo_addr;
  logic [wordsize-1:0]      r_wdata;
  logic [wordsize-1:0]      r_lo;
  logic [wordsize-1:0]      r_hi;

  logic [LWB-1:0]           w_off_in;
  logic [NW-1:0]            w_n_in;
  logic                     w_span_in;
  logic                     w_full_in;
  logic [addr_size-LWB-1:0] w_hi_addr;
  logic [wordsize-1:0]      w_nmask;
  logic [LWB+2:0]           w_sh;
  logic [2*wordsize-1:0]    w_pair;
  logic [2*wordsize-1:0]    w_mask2;
  logic [2*wordsize-1:0]    w_data2;
  logic [2*wordsize-1:0]    w_merged;
  logic [wordsize-1:0]      w_result;

  // Access length in bytes, clamped to one word
  always_comb begin
    w_n_in = NW'(WB);
    if (int'(cpu_size) <= LWB) w_n_in = NW'(1) << cpu_size;
  end

  assign w_off_in  = cpu_addr[LWB-1:0];
  assign w_span_in = ({1'b0, w_off_in} + w_n_in) > NW'(WB);
  assign w_full_in = cpu_we && (w_off_in == '0) && (w_n_in == NW'(WB));
  assign w_hi_addr = r_lo_addr + 1'b1;

  always_comb begin
    w_nmask = '0;
    for (int b = 0; b < WB; b++) begin
      if (b < int'(r_n)) w_nmask[8*b +: 8] = 8'hFF;
    end
  end

  // {hi,lo} is treated as one little-endian double word; the access lives at byte offset r_off
  assign w_sh     = {r_off, 3'b000};
  assign w_pair   = {r_hi, r_lo};
  assign w_mask2  = {{wordsize{1'b0}}, w_nmask} << w_sh;
  assign w_data2  = {{wordsize{1'b0}}, r_wdata & w_nmask} << w_sh;
  assign w_merged = (w_pair & ~w_mask2) | w_data2;
  assign w_result = wordsize'(w_pair >> w_sh) & w_nmask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_span    <= 1'b0;
      r_off     <= '0;
      r_n       <= '0;
      r_lo_addr <= '0;
      r_wdata   <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cpu_req) begin
        r_we      <= cpu_we;
        r_span    <= w_span_in;
        r_off     <= w_off_in;
        r_n       <= w_n_in;
        r_lo_addr <= cpu_addr[addr_size-1:LWB];
        r_wdata   <= cpu_wdata;
      end
      // Read data lags the address by one cycle
      if (r_state == S_RD_HI) r_lo <= mem_rdata;
      if (r_state == S_RD_END) begin
        if (r_span) r_hi <= mem_rdata;
        else        r_lo <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) w_next = w_full_in ? S_WR_LO : S_RD_LO;
      end
      S_RD_LO: begin
        mem_addr = r_lo_addr;
        w_next   = r_span ? S_RD_HI : S_RD_END;
      end
      S_RD_HI: begin
        mem_addr = w_hi_addr;
        w_next   = S_RD_END;
      end
      S_RD_END: begin
        w_next = r_we ? S_WR_LO : S_DONE;
      end
      S_WR_LO: begin
        mem_addr  = r_lo_addr;
        mem_we    = 1'b1;
        mem_wdata = w_merged[wordsize-1:0];
        w_next    = r_span ? S_WR_HI : S_DONE;
      end
      S_WR_HI: begin
        mem_addr  = w_hi_addr;
        mem_we    = 1'b1;
        mem_wdata = w_merged[2*wordsize-1:wordsize];
        w_next    = S_DONE;
      end
      S_DONE: begin
        cpu_ready = 1'b1;
        cpu_rdata = r_we ? '0 : w_result;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reflet_align_bridge.sv
// tb/tb_reflet_align_bridge.sv - directed self-checking bench for reflet_align_bridge
// Word memory model with one-cycle read latency; preload port avoids mixed-assignment races.
module tb_reflet_align_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int rd_cnt = 0;
  int rdy_cnt = 0;

  always #5 clk = ~clk;

  reflet_align_bridge #(.wordsize(32), .addr_size(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) we_cnt++;
      if (!mem_we && mem_addr != '0) rd_cnt++;
      if (cpu_ready) rdy_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic access(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0; cpu_addr = '0; cpu_wdata = '0;
    lat = 99;
    rd  = '0;
    for (int i = 1; i <= 20; i++) begin
      if (cpu_ready) begin
        lat = i;
        rd  = cpu_rdata;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 64'(cpu_ready), 64'd0);
    check({tag, "_rdata"}, 64'(cpu_rdata), 64'd0);
    check({tag, "_maddr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mwdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_mwe"}, 64'(mem_we), 64'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  int          we0, rd0, rdy0;

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b0;

    // Case 1: reset held two cycles in the middle of a load
    preload(10'h103, 32'h0D0C0B0A);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h40C;
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    we0 = we_cnt; rdy0 = rdy_cnt;
    repeat (10) @(negedge clk);
    check("midrst_idle_we", 64'(we_cnt - we0), 64'd0);
    check("midrst_idle_rdy", 64'(rdy_cnt - rdy0), 64'd0);

    // Case 2: aligned full-word store, no read phase
    preload(10'h100, 32'h12345678);
    we0 = we_cnt; rd0 = rd_cnt;
    access(1'b1, 2'd2, 32'h400, 32'hABCDEF00, lat, rd);
    check("c2_lat", 64'(lat), 64'd2);
    check("c2_rdata", 64'(rd), 64'd0);
    check("c2_we_cnt", 64'(we_cnt - we0), 64'd1);
    check("c2_rd_cnt", 64'(rd_cnt - rd0), 64'd0);
    check("c2_mem", 64'(mem[10'h100]), 64'hABCDEF00);

    // Case 3: word store straddling 0x101/0x102
    preload(10'h101, 32'h00000000);
    preload(10'h102, 32'hFFFFFFFF);
    we0 = we_cnt;
    access(1'b1, 2'd2, 32'h406, 32'h01020304, lat, rd);
    check("c3_lat", 64'(lat), 64'd6);
    check("c3_we_cnt", 64'(we_cnt - we0), 64'd2);
    check("c3_mem_lo", 64'(mem[10'h101]), 64'h03040000);
    check("c3_mem_hi", 64'(mem[10'h102]), 64'hFFFF0102);

    // Case 4: byte store inside a word, upper data bits must be ignored
    preload(10'h103, 32'h0D0C0B0A);
    we0 = we_cnt;
    access(1'b1, 2'd0, 32'h40D, 32'h123456AA, lat, rd);
    check("c4_lat", 64'(lat), 64'd4);
    check("c4_we_cnt", 64'(we_cnt - we0), 64'd1);
    check("c4_mem", 64'(mem[10'h103]), 64'h0D0CAA0A);

    // Case 5: halfword load straddling 0x103/0x104
    preload(10'h103, 32'h0D0C0B0A);
    preload(10'h104, 32'h11223344);
    we0 = we_cnt;
    access(1'b0, 2'd1, 32'h40F, 32'h0, lat, rd);
    check("c5_lat", 64'(lat), 64'd4);
    check("c5_rdata", 64'(rd), 64'h0000440D);
    check("c5_we_cnt", 64'(we_cnt - we0), 64'd0);

    // Extra: aligned non-span word load, byte load zero-extension, size 3 clamps to a word
    access(1'b0, 2'd2, 32'h40C, 32'h0, lat, rd);
    check("ld_word_lat", 64'(lat), 64'd3);
    check("ld_word_rdata", 64'(rd), 64'h0D0C0B0A);
    access(1'b0, 2'd0, 32'h40E, 32'h0, lat, rd);
    check("ld_byte_rdata", 64'(rd), 64'h0000000C);
    preload(10'h105, 32'h0);
    access(1'b1, 2'd3, 32'h414, 32'hCAFEF00D, lat, rd);
    check("st_clamp_lat", 64'(lat), 64'd2);
    check("st_clamp_mem", 64'(mem[10'h105]), 64'hCAFEF00D);

    // Address wrap: span at the top word reads word 0 as hi
    preload(10'h3FF, 32'hA1B2C3D4);
    preload(10'h000, 32'h11223344);
    access(1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, lat, rd);
    check("wrap_lat", 64'(lat), 64'd4);
    check("wrap_rdata", 64'(rd), 64'h3344A1B2);

    // Case 6: reset during RD_HI of the case-3 store aborts it cleanly
    preload(10'h101, 32'h00000000);
    preload(10'h102, 32'hFFFFFFFF);
    we0 = we_cnt; rdy0 = rdy_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd2; cpu_addr = 32'h406; cpu_wdata = 32'h01020304;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(negedge clk);
    check("c6_rdhi_addr", 64'(mem_addr), 64'h102);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("c6_we_cnt", 64'(we_cnt - we0), 64'd0);
    check("c6_rdy_cnt", 64'(rdy_cnt - rdy0), 64'd0);
    check("c6_mem_lo", 64'(mem[10'h101]), 64'h00000000);
    check("c6_mem_hi", 64'(mem[10'h102]), 64'hFFFFFFFF);
    preload(10'h100, 32'h55555555);
    access(1'b1, 2'd2, 32'h400, 32'hABCDEF00, lat, rd);
    check("c6_after_lat", 64'(lat), 64'd2);
    check("c6_after_mem", 64'(mem[10'h100]), 64'hABCDEF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
